// File: rtl/pixel_write_buffer.sv
// rtl/pixel_write_buffer.sv - round-robin engine arbiter feeding a buffered pixel RAM writer
// Optional macro PIXEL_COLOR_MAP_EN remaps iteration counts to colour bytes.
module pixel_write_buffer #(
  parameter int NUM_PROC   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480
) (
  input  logic                          clk_iCLK,
  input  logic                          reset,
  input  logic [NUM_PROC-1:0]           engine_req,
  output logic [NUM_PROC-1:0]           req_ack,
  input  logic [26:0]                   in_word,
  input  logic                          wr_ready,
  output logic                          wr_en,
  output logic [18:0]                   wr_addr,
  output logic [7:0]                    wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_cnt
);

  localparam int PW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_ARB, ST_ACK, ST_CAP} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       rr_q, rr_d, sel_q, sel_d;
  logic [NUM_PROC-1:0] req_ack_q, req_ack_d;
  logic                found;
  logic [PW-1:0]       pick, cand;

  logic [9:0]          cap_x;
  logic [8:0]          cap_y;
  logic [7:0]          cap_iter, cap_data;
  logic [18:0]         cap_addr;
  logic                in_range, push, drop, pop;

  logic [26:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic                wr_en_q, wr_en_d;
  logic [18:0]         wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;

  // Grant is only issued from ARB when a FIFO slot is guaranteed for the captured result.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    sel_d     = sel_q;
    req_ack_d = '0;
    found     = 1'b0;
    pick      = '0;
    cand      = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      cand = PW'((int'(rr_q) + i) % NUM_PROC);
      if (!found && engine_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    case (state_q)
      ST_ARB: begin
        if (found && (int'(count_q) < FIFO_DEPTH)) begin
          sel_d           = pick;
          req_ack_d[pick] = 1'b1;
          state_d         = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_CAP;
        rr_d    = (int'(sel_q) == NUM_PROC - 1) ? '0 : sel_q + 1'b1;
      end
      ST_CAP:  state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  assign cap_x    = in_word[26:17];
  assign cap_y    = in_word[16:8];
  assign cap_iter = in_word[7:0];
  assign in_range = (int'(cap_x) < H_RES) && (int'(cap_y) < V_RES);
  assign cap_addr = 19'(cap_x) + 19'(cap_y) * 19'(H_RES);

`ifdef PIXEL_COLOR_MAP_EN
  assign cap_data = (cap_iter == 8'hFF) ? 8'h00 : {cap_iter[4:0], cap_iter[7:5]};
`else
  assign cap_data = cap_iter;
`endif

  assign push = (state_q == ST_CAP) && in_range;
  assign drop = (state_q == ST_CAP) && !in_range;
  assign pop  = (count_q != '0) && wr_ready;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    wr_en_d    = pop;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (pop) begin
      wr_addr_d = mem_q[rd_ptr_q][26:8];
      wr_data_d = mem_q[rd_ptr_q][7:0];
    end
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_iCLK or posedge reset) begin
    if (reset) begin
      state_q    <= ST_ARB;
      rr_q       <= '0;
      sel_q      <= '0;
      req_ack_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      sel_q      <= sel_d;
      req_ack_q  <= req_ack_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk_iCLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cap_addr, cap_data};
    end
  end

  assign req_ack    = req_ack_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign fifo_level = count_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_pixel_write_buffer.sv
// tb/tb_pixel_write_buffer.sv - self-checking bench for pixel_write_buffer
module tb_pixel_write_buffer;

  localparam int NP = 4;
  localparam int DEPTH = 8;
  localparam int HR = 640;
  localparam int VR = 480;
  localparam int QN = 300;

`ifdef PIXEL_COLOR_MAP_EN
  localparam int PIX10 = 'h80, PIX7F = 'hFB, PIXFF = 'h00, PIX21 = 'h09;
`else
  localparam int PIX10 = 'h10, PIX7F = 'h7F, PIXFF = 'hFF, PIX21 = 'h21;
`endif

  logic            clk_iCLK = 1'b0;
  logic            reset = 1'b0;
  logic [NP-1:0]   engine_req = '0;
  logic [NP-1:0]   req_ack;
  logic [26:0]     in_word = '0;
  logic            wr_ready = 1'b0;
  logic            wr_en;
  logic [18:0]     wr_addr;
  logic [7:0]      wr_data;
  logic [3:0]      fifo_level;
  logic [7:0]      drop_cnt;

  always #5 clk_iCLK = ~clk_iCLK;

  pixel_write_buffer #(.NUM_PROC(NP), .FIFO_DEPTH(DEPTH), .H_RES(HR), .V_RES(VR)) dut (
    .clk_iCLK(clk_iCLK), .reset(reset), .engine_req(engine_req), .req_ack(req_ack),
    .in_word(in_word), .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  int n_checks = 0;
  int n_pass = 0;

  logic [26:0] eng_mem [NP][QN];
  int          eng_head [NP];
  int          eng_tail [NP];
  logic [26:0] exp_q [$];
  int          ack_eng [$];
  int          ack_cyc [$];
  int m_pushed, m_pops, m_drops, pend_push0, pend_push1, pend_drop0, pend_drop1;
  int m_rr, since_ack, lvl_prev, cyc, n_acks, n_wr, rdy_mode;
  int last_ack_cyc, last_ack_eng, last_wr_cyc;
  logic [NP-1:0] req_prev;
  logic [18:0]   last_wr_addr;
  logic [7:0]    last_wr_data;

  typedef struct {
    int eng; int x; int y; int it;
    int exp_wr; int exp_addr; int exp_data; int exp_drop;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic logic [7:0] pix(input logic [7:0] it);
`ifdef PIXEL_COLOR_MAP_EN
    if (it == 8'hFF) return 8'h00;
    return {it[4:0], it[7:5]};
`else
    return it;
`endif
  endfunction

  task automatic add_item(input int e, input int x, input int y, input int it);
    logic [9:0] xv; logic [8:0] yv; logic [7:0] iv;
    xv = x[9:0]; yv = y[8:0]; iv = it[7:0];
    eng_mem[e][eng_tail[e]] = {xv, yv, iv};
    eng_tail[e]++;
  endtask

  function automatic bit model_idle();
    bit q_empty;
    q_empty = 1'b1;
    for (int i = 0; i < NP; i++) if (eng_head[i] != eng_tail[i]) q_empty = 1'b0;
    return q_empty && (exp_q.size() == 0) && (pend_push0 + pend_push1 + pend_drop0 + pend_drop1 == 0);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NP; i++) begin eng_head[i] = 0; eng_tail[i] = 0; end
    exp_q.delete(); ack_eng.delete(); ack_cyc.delete();
    m_pushed = 0; m_pops = 0; m_drops = 0;
    pend_push0 = 0; pend_push1 = 0; pend_drop0 = 0; pend_drop1 = 0;
    m_rr = 0; since_ack = 100; lvl_prev = 0; req_prev = '0; engine_req = '0;
    n_acks = 0; n_wr = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_req_ack", req_ack, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_wr_addr", wr_addr, 0);
    clear_model();
    @(negedge clk_iCLK);
    reset = 1'b0;
  endtask

  // One clock of engine behaviour plus a cycle-level check of every output against the rules.
  task automatic step();
    int g, a, c, x, y, addr;
    logic [26:0] w, e;
    logic [18:0] a19;
    @(negedge clk_iCLK);
    cyc++;
    m_pushed += pend_push1; pend_push1 = pend_push0; pend_push0 = 0;
    m_drops  += pend_drop1; pend_drop1 = pend_drop0; pend_drop0 = 0;

    chk("wr_en", wr_en, (lvl_prev > 0 && wr_ready) ? 1 : 0);
    if (wr_en) begin
      n_wr++; m_pops++;
      last_wr_cyc = cyc; last_wr_addr = wr_addr; last_wr_data = wr_data;
      chk("wr_has_expect", (exp_q.size() != 0) ? 1 : 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", wr_addr, e[26:8]);
        chk("wr_data", wr_data, e[7:0]);
      end
    end
    chk("fifo_level", fifo_level, m_pushed - m_pops);
    chk("drop_cnt", drop_cnt, (m_drops > 255) ? 255 : m_drops);

    since_ack++;
    g = -1;
    if (since_ack >= 3 && lvl_prev < DEPTH) begin
      for (int i = 0; i < NP; i++) begin
        c = (m_rr + i) % NP;
        if (g < 0 && req_prev[c]) g = c;
      end
    end
    chk("req_ack", req_ack, (g < 0) ? 0 : (1 << g));
    if (g >= 0) begin
      m_rr = (g + 1) % NP;
      since_ack = 0;
    end

    if (req_ack != '0) begin
      a = 0;
      for (int i = NP - 1; i >= 0; i--) if (req_ack[i]) a = i;
      n_acks++; last_ack_cyc = cyc; last_ack_eng = a;
      ack_eng.push_back(a); ack_cyc.push_back(cyc);
      chk("ack_engine_pending", (eng_head[a] != eng_tail[a]) ? 1 : 0, 1);
      if (eng_head[a] != eng_tail[a]) begin
        w = eng_mem[a][eng_head[a]];
        eng_head[a]++;
        in_word = w;
        x = int'(w[26:17]); y = int'(w[16:8]);
        if (x < HR && y < VR) begin
          addr = x + y * HR;
          a19 = addr[18:0];
          exp_q.push_back({a19, pix(w[7:0])});
          pend_push0 = 1;
        end else begin
          pend_drop0 = 1;
        end
      end
    end

    lvl_prev = m_pushed - m_pops;
    for (int i = 0; i < NP; i++) req_prev[i] = (eng_head[i] != eng_tail[i]);
    engine_req = req_prev;
    wr_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
  endtask

  initial begin
    int t0, nw0, tbl_drops, accepted, rx, ry;
    cyc = 0; rdy_mode = 1; wr_ready = 1'b1;
    clear_model();

    tbl[0] = '{0, 5, 2, 'h10, 1, 1285, PIX10, 0};
    tbl[1] = '{1, 640, 0, 'h33, 0, 0, 0, 1};
    tbl[2] = '{2, 639, 479, 'h7F, 1, 307199, PIX7F, 0};
    tbl[3] = '{3, 0, 480, 'h01, 0, 0, 0, 1};
    tbl[4] = '{0, 0, 0, 'hFF, 1, 0, PIXFF, 0};
    tbl[5] = '{1, 100, 1, 'h21, 1, 740, PIX21, 0};
    tbl[6] = '{3, 1023, 511, 'h00, 0, 0, 0, 1};

    @(negedge clk_iCLK);
    do_reset();

    tbl_drops = 0;
    foreach (tbl[k]) begin
      add_item(tbl[k].eng, tbl[k].x, tbl[k].y, tbl[k].it);
      nw0 = n_wr;
      last_ack_cyc = -100; last_wr_cyc = -100;
      step();
      t0 = cyc;
      repeat (7) step();
      tbl_drops += tbl[k].exp_drop;
      chk($sformatf("tbl%0d_ack_latency", k), last_ack_cyc - t0, 1);
      chk($sformatf("tbl%0d_ack_engine", k), last_ack_eng, tbl[k].eng);
      chk($sformatf("tbl%0d_write_count", k), n_wr - nw0, tbl[k].exp_wr);
      if (tbl[k].exp_wr != 0) begin
        chk($sformatf("tbl%0d_wr_latency", k), last_wr_cyc - t0, 4);
        chk($sformatf("tbl%0d_wr_addr", k), last_wr_addr, tbl[k].exp_addr);
        chk($sformatf("tbl%0d_wr_data", k), last_wr_data, tbl[k].exp_data);
      end
      chk($sformatf("tbl%0d_drop_cnt", k), drop_cnt, tbl_drops);
    end

    // All four engines requesting: grants rotate and are spaced three cycles apart.
    @(negedge clk_iCLK);
    do_reset();
    for (int e = 0; e < NP; e++) begin
      add_item(e, e, 1, e + 1);
      add_item(e, e + 10, 2, e + 5);
    end
    repeat (40) step();
    chk("rr_ack_total", ack_eng.size(), 8);
    if (ack_eng.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), ack_eng[i], i % NP);
      for (int i = 1; i < 5; i++) chk($sformatf("rr_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 3);
    end
    chk("rr_writes", n_wr, 8);

    // Stalled RAM port: FIFO fills to depth, ninth grant waits for wr_ready.
    @(negedge clk_iCLK);
    do_reset();
    rdy_mode = 0; wr_ready = 1'b0;
    for (int i = 0; i < 9; i++) add_item(i % NP, 20 + i, 3 * i, 40 + i);
    repeat (40) step();
    chk("fill_acks", n_acks, 8);
    chk("fill_level", fifo_level, 8);
    chk("fill_no_writes", n_wr, 0);
    rdy_mode = 1; wr_ready = 1'b1;
    repeat (40) step();
    chk("drain_acks", n_acks, 9);
    chk("drain_writes", n_wr, 9);
    chk("drain_level", fifo_level, 0);

    // Reset while a grant is outstanding discards the in-flight result.
    @(negedge clk_iCLK);
    do_reset();
    add_item(2, 10, 10, 5);
    step();
    @(negedge clk_iCLK);
    chk("inflight_ack", req_ack, 4'b0100);
    do_reset();
    repeat (10) step();
    chk("inflight_no_write", n_wr, 0);

    // Drop counter saturation.
    @(negedge clk_iCLK);
    do_reset();
    for (int i = 0; i < 65 * NP; i++) add_item(i % NP, 640 + (i % 300), i % 512, i);
    for (int k = 0; k < 1200 && !model_idle(); k++) step();
    repeat (4) step();
    chk("sat_drained", model_idle(), 1);
    chk("sat_drop_cnt", drop_cnt, 255);

    // Randomized traffic with a random RAM back-pressure pattern.
    @(negedge clk_iCLK);
    do_reset();
    rdy_mode = 2;
    accepted = 0;
    for (int i = 0; i < 40 * NP; i++) begin
      rx = $urandom_range(0, 700);
      ry = $urandom_range(0, 511);
      if (rx < HR && ry < VR) accepted++;
      add_item($urandom_range(0, NP - 1), rx, ry, $urandom_range(0, 255));
    end
    for (int k = 0; k < 4000 && !model_idle(); k++) step();
    rdy_mode = 1;
    repeat (4) step();
    chk("rand_drained", model_idle(), 1);
    chk("rand_writes", n_wr, accepted);
    chk("rand_acks", n_acks, 40 * NP);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pixel_write_buffer.md
PIXEL_WRITE_BUFFER -- requirements
Module: pixel_write_buffer

Interface
REQ-001 Parameter NUM_PROC, default 4, is the number of engine request/ack lines.
REQ-002 Parameter FIFO_DEPTH, default 8, is the number of buffered pixel writes (power of 2).
REQ-003 Parameter H_RES, default 640, is the pixels per line used in the address computation.
REQ-004 Parameter V_RES, default 480, is the number of lines.
REQ-005 clk_iCLK  in  1  engine-domain clock; all logic is on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 engine_req  in  NUM_PROC  per-engine result-ready request; any number of bits may be set.
REQ-008 req_ack  out  NUM_PROC  one-hot grant; the granted engine drives in_word in the following cycle.
REQ-009 in_word  in  27  engine result: [26:17] x, [16:8] y, [7:0] iteration count.
REQ-010 wr_ready  in  1  RAM write port can accept a write this cycle.
REQ-011 wr_en  out  1  registered RAM write strobe.
REQ-012 wr_addr  out  19  registered RAM address.
REQ-013 wr_data  out  8  registered RAM data.
REQ-014 fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-015 drop_cnt  out  8  saturating count of out-of-range results discarded.

Function
REQ-016 The arbiter SHALL use three states, ARB -> ACK -> CAP -> ARB, advancing one state per cycle.
REQ-017 In ARB: if any engine_req bit is set and fifo_level < FIFO_DEPTH, select the requester by round-robin starting at pointer rr and go to ACK; otherwise stay in ARB.
REQ-018 In ACK, req_ack SHALL be high for exactly one cycle on the selected bit only; rr becomes (selected+1) mod NUM_PROC.
REQ-019 In CAP, in_word SHALL be sampled; it is accepted if x < H_RES and y < V_RES, otherwise dropped and drop_cnt incremented (saturating at 255).
REQ-020 Accepted results SHALL be pushed at the end of CAP with addr = x + y*H_RES (19 bits, no wrap possible in range) and data per REQ-027/028.
REQ-021 Sustained throughput SHALL be at most one grant per 3 cycles; a new grant never overlaps an outstanding one.
REQ-022 When the FIFO is non-empty and wr_ready is high, the head SHALL be popped; wr_en, wr_addr and wr_data are registered, so wr_en is high the next cycle.
REQ-023 With an empty FIFO and wr_ready high, wr_en SHALL rise 2 cycles after CAP (engine_req sampled in cycle 0 -> req_ack in cycle 1 -> CAP in cycle 2 -> wr_en in cycle 4).
REQ-024 A simultaneous push and pop SHALL leave fifo_level unchanged; pop from empty and push to full SHALL never occur.
REQ-025 When wr_ready is low, wr_en SHALL be low the next cycle; FIFO contents are held.

Reset
REQ-026 On reset assertion, immediately: state = ARB, req_ack = 0, wr_en = 0, wr_addr = 0, wr_data = 0, FIFO emptied (fifo_level = 0), rr = 0, drop_cnt = 0. A result in flight during ACK/CAP is discarded.

Configuration
REQ-027 With macro PIXEL_COLOR_MAP_EN defined, data SHALL be 8'h00 when iteration = 255, otherwise {iter[4:0], iter[7:5]}.
REQ-028 Without PIXEL_COLOR_MAP_EN, data SHALL equal the raw iteration count.

Verification
REQ-029 engine_req[0] high in cycle 0 with x=5, y=2, iter=0x10 -> req_ack[0] high only in cycle 1, wr_en in cycle 4, wr_addr=1285, wr_data=0x10 (macro off).
REQ-030 All four engine_req held high -> acks in order 0,1,2,3,0, each one cycle wide, 3 cycles apart.
REQ-031 wr_ready low and 9 requests -> 8 acks, fifo_level=8, 9th ack withheld until wr_ready rises; then 9 writes in FIFO order.
REQ-032 x=640, y=0 -> no wr_en, drop_cnt=1; x=639, y=479 -> wr_addr=307199.
REQ-033 reset asserted during ACK -> req_ack=0 and fifo_level=0 before the next clock edge; no wr_en follows.
REQ-034 Macro on: iter=255 -> wr_data=0x00; iter=0x21 -> wr_data=0x09.
